// File: rtl/mux_scan_n1_if.sv
// Channel bus for mux_scan_n1: packed channel inputs, select/scan controls,
// and the registered tagged output.
interface mux_scan_n1_if #(
    parameter int N_CH    = 16,
    parameter int W       = 1,
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8
);
    logic [N_CH*W-1:0]  a;
    logic [SEL_W-1:0]   b;
    logic               mode;
    logic [DWELL_W-1:0] dwell;
    logic               en;
    logic [W-1:0]       out;
    logic [SEL_W-1:0]   ch;
    logic               wrap;
    logic               err;

    modport master (
        output a, b, mode, dwell, en,
        input  out, ch, wrap, err
    );

    modport slave (
        input  a, b, mode, dwell, en,
        output out, ch, wrap, err
    );
endinterface

// File: rtl/mux_scan_n1.sv
// Registered N:1 channel multiplexer with direct select and an auto-scan mode
// that steps through all channels, holding each for dwell+1 enabled cycles.
module mux_scan_n1 #(
    parameter int N_CH    = 16,
    parameter int W       = 1,
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_scan_n1_if.slave bus
);
    localparam logic [0:0] ST_DIRECT = 1'b0;
    localparam logic [0:0] ST_SCAN   = 1'b1;

    localparam logic [SEL_W:0]   NCH_X = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_CH-1);

    logic [0:0]         state_q, state_d;
    logic [SEL_W-1:0]   cur_q, cur_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]       out_q, out_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;

    logic               b_ok;
    logic [W-1:0]       a_b;
    logic [W-1:0]       a_cur;

    assign b_ok = ({1'b0, bus.b} < NCH_X);

    // Constant-index slices only, so out-of-range selects never index past a.
    always_comb begin
        a_b   = '0;
        a_cur = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (bus.b == SEL_W'(i)) a_b   = bus.a[i*W +: W];
            if (cur_q == SEL_W'(i)) a_cur = bus.a[i*W +: W];
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ch_d    = ch_q;
        wrap_d  = wrap_q;
        err_d   = err_q;
        if (bus.en) begin
            if (state_q == ST_SCAN && bus.mode) begin
                out_d = a_cur;
                ch_d  = cur_q;
                err_d = 1'b0;
                if (cnt_q >= bus.dwell) begin
                    cnt_d  = '0;
                    cur_d  = (cur_q == LAST) ? '0 : cur_q + SEL_W'(1);
                    wrap_d = (cur_q == LAST);
                end else begin
                    cnt_d  = cnt_q + DWELL_W'(1);
                    wrap_d = 1'b0;
                end
            end else begin
                // Direct rules also cover scan exit and the scan entry cycle.
                out_d   = b_ok ? a_b : '0;
                ch_d    = bus.b;
                err_d   = ~b_ok;
                wrap_d  = 1'b0;
                cnt_d   = '0;
                state_d = bus.mode ? ST_SCAN : ST_DIRECT;
                if (bus.mode) cur_d = b_ok ? bus.b : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_DIRECT;
            cur_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            ch_q    <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ch_q    <= ch_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.ch   = ch_q;
    assign bus.wrap = wrap_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_mux_scan_n1.sv
// Scoreboard bench for mux_scan_n1 across three channel counts (16, 10, 4).
module tb_mux_scan_n1;
    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mux_scan_n1_if #(.N_CH(16), .W(1), .SEL_W(4), .DWELL_W(8)) if16 ();
    mux_scan_n1_if #(.N_CH(10), .W(1), .SEL_W(4), .DWELL_W(8)) if10 ();
    mux_scan_n1_if #(.N_CH(4),  .W(4), .SEL_W(2), .DWELL_W(8)) if4 ();

    mux_scan_n1 #(.N_CH(16), .W(1), .SEL_W(4), .DWELL_W(8)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    mux_scan_n1 #(.N_CH(10), .W(1), .SEL_W(4), .DWELL_W(8)) u10 (.clk(clk), .rst_n(rst_n), .bus(if10));
    mux_scan_n1 #(.N_CH(4),  .W(4), .SEL_W(2), .DWELL_W(8)) u4  (.clk(clk), .rst_n(rst_n), .bus(if4));

    typedef struct {
        int         stamp;
        int         dut;
        logic [7:0] out;
        logic [7:0] ch;
        logic       wrap;
        logic       err;
        string      name;
    } exp_t;

    exp_t sbq[$];

    function automatic void get_act(input int d, output logic [7:0] o, output logic [7:0] c,
                                    output logic w, output logic e);
        case (d)
            0:       begin o = {7'b0, if16.out}; c = {4'b0, if16.ch}; w = if16.wrap; e = if16.err; end
            1:       begin o = {7'b0, if10.out}; c = {4'b0, if10.ch}; w = if10.wrap; e = if10.err; end
            default: begin o = {4'b0, if4.out};  c = {6'b0, if4.ch};  w = if4.wrap;  e = if4.err;  end
        endcase
    endfunction

    task automatic compare(input exp_t x);
        logic [7:0] o, c;
        logic w, e;
        get_act(x.dut, o, c, w, e);
        n_vec++;
        if (o !== x.out || c !== x.ch || w !== x.wrap || e !== x.err) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t: got out=%0h ch=%0d wrap=%b err=%b, want out=%0h ch=%0d wrap=%b err=%b",
                     x.name, x.dut, $time, o, c, w, e, x.out, x.ch, x.wrap, x.err);
        end
    endtask

    // Expected result of the next rising edge.
    task automatic push(input int d, input int o, input int c, input bit w, input bit e, input string nm);
        exp_t x;
        x.stamp = cyc + 1; x.dut = d; x.out = 8'(o); x.ch = 8'(c);
        x.wrap = w; x.err = e; x.name = nm;
        sbq.push_back(x);
    endtask

    task automatic chk_now(input int d, input string nm);
        exp_t x;
        x.stamp = cyc; x.dut = d; x.out = '0; x.ch = '0;
        x.wrap = 1'b0; x.err = 1'b0; x.name = nm;
        compare(x);
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].stamp <= cyc) begin
            exp_t x;
            x = sbq.pop_front();
            if (x.stamp < cyc) begin
                n_vec++; n_bad++;
                $display("FAIL %s late: stamp %0d seen at cycle %0d", x.name, x.stamp, cyc);
            end else begin
                compare(x);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sbq.size() > 0; k++) @(negedge clk);
        #1;
        n_vec++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    bit   sweep_bits [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
    int   scan_ch    [13] = '{2,2,2,3,3,3,0,0,0,1,1,1,2};
    int   scan_out   [13] = '{4,4,4,8,8,8,1,1,1,2,2,2,4};

    initial begin
        rst_n = 1'b0;
        if16.a = '0; if16.b = '0; if16.mode = 1'b0; if16.dwell = '0; if16.en = 1'b0;
        if10.a = '0; if10.b = '0; if10.mode = 1'b0; if10.dwell = '0; if10.en = 1'b0;
        if4.a  = '0; if4.b  = '0; if4.mode  = 1'b0; if4.dwell  = '0; if4.en  = 1'b0;
        #12;
        chk_now(0, "reset16");
        chk_now(1, "reset10");
        chk_now(2, "reset4");
        @(negedge clk);
        rst_n = 1'b1;

        // Direct sweep, N_CH=16
        if16.a = 16'hA5C3; if16.en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if16.b = 4'(i);
            push(0, int'(sweep_bits[i]), i, 1'b0, 1'b0, "dsweep");
        end
        tick(); if16.en = 1'b0;

        // Out-of-range select, N_CH=10
        if10.a = 10'h3FF; if10.en = 1'b1;
        if10.b = 4'd12; push(1, 0, 12, 1'b0, 1'b1, "oor12");
        tick(); if10.b = 4'd3;  push(1, 1, 3,  1'b0, 1'b0, "oor_back3");
        tick(); if10.b = 4'd10; push(1, 0, 10, 1'b0, 1'b1, "oor10");
        tick(); if10.b = 4'd9;  push(1, 1, 9,  1'b0, 1'b0, "edge9");
        tick(); if10.en = 1'b0;

        // Scan dwell=2 from channel 2, N_CH=4
        if4.a = 16'h8421; if4.en = 1'b1; if4.dwell = 8'd2; if4.b = 2'd2; if4.mode = 1'b1;
        push(2, 4, 2, 1'b0, 1'b0, "scan_entry");
        for (int i = 0; i < 13; i++) begin
            tick();
            push(2, scan_out[i], scan_ch[i], (i == 5), 1'b0, "scan_dw2");
        end
        tick(); if4.mode = 1'b0; if4.b = 2'd0; push(2, 1, 0, 1'b0, 1'b0, "scan_exit");

        // Enable freeze mid-dwell, dwell=3
        tick(); if4.dwell = 8'd3; if4.b = 2'd1; if4.mode = 1'b1; push(2, 2, 1, 1'b0, 1'b0, "frz_entry");
        for (int i = 0; i < 2; i++) begin tick(); push(2, 2, 1, 1'b0, 1'b0, "frz_pre"); end
        for (int i = 0; i < 5; i++) begin tick(); if4.en = 1'b0; push(2, 2, 1, 1'b0, 1'b0, "frz_hold"); end
        for (int i = 0; i < 2; i++) begin tick(); if4.en = 1'b1; push(2, 2, 1, 1'b0, 1'b0, "frz_post"); end
        for (int i = 0; i < 4; i++) begin tick(); push(2, 4, 2, 1'b0, 1'b0, "frz_next"); end
        tick(); push(2, 8, 3, 1'b0, 1'b0, "frz_ch3");

        // Live dwell change 7 -> 2 at cnt=5
        tick(); if4.mode = 1'b0; if4.b = 2'd0; push(2, 1, 0, 1'b0, 1'b0, "ld_exit");
        tick(); if4.dwell = 8'd7; if4.mode = 1'b1; push(2, 1, 0, 1'b0, 1'b0, "ld_entry");
        for (int i = 0; i < 5; i++) begin tick(); push(2, 1, 0, 1'b0, 1'b0, "ld_ch0"); end
        tick(); if4.dwell = 8'd2; push(2, 1, 0, 1'b0, 1'b0, "ld_cut");
        for (int k = 1; k < 4; k++)
            for (int j = 0; j < 3; j++) begin
                tick();
                push(2, 1 << k, k, (k == 3 && j == 2), 1'b0, "ld_after");
            end
        for (int i = 0; i < 2; i++) begin tick(); if4.en = 1'b0; push(2, 8, 3, 1'b1, 1'b0, "wrap_hold"); end
        tick(); if4.en = 1'b1; push(2, 1, 0, 1'b0, 1'b0, "wrap_drop");
        tick(); if4.en = 1'b0;

        // dwell=0 wrap, then async reset mid-scan, N_CH=16
        if16.a = 16'hFFFF; if16.dwell = 8'd0; if16.b = 4'd14; if16.mode = 1'b1; if16.en = 1'b1;
        push(0, 1, 14, 1'b0, 1'b0, "rs_entry");
        tick(); push(0, 1, 14, 1'b0, 1'b0, "rs_s14");
        tick(); push(0, 1, 15, 1'b1, 1'b0, "rs_s15");
        tick(); push(0, 1, 0,  1'b0, 1'b0, "rs_s0");
        drain();
        #1 rst_n = 1'b0;
        #1 chk_now(0, "rst_async");
        #1 rst_n = 1'b1;
        push(0, 1, 14, 1'b0, 1'b0, "rs_resume_direct");
        tick(); push(0, 1, 14, 1'b0, 1'b0, "rs_s14b");
        tick(); push(0, 1, 15, 1'b1, 1'b0, "rs_s15b");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
